// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives a request; the slave returns the registered difference and status.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, bin,
        input  diff, bout, busy, done
    );

    modport slave (
        input  start, a, b, bin,
        output diff, bout, busy, done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell is reused for WIDTH cycles.
// Operands are latched on start and consumed LSB first; result and borrow are registered at the end.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow;
    logic             bout_reg;
    logic             x;
    logic             y;
    logic             d;
    logic             borrow_next;
    logic             last_bit;
    logic             accept;
    logic             busy_int;
    logic             done_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_int   = 1'b0;
        done_int   = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy_int = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_int   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operands shift right each cycle, so bit 0 is always the bit being processed.
    always_comb begin
        x           = a_reg[0];
        y           = b_reg[0];
        d           = x ^ y ^ borrow;
        borrow_next = (~x & y) | (~(x ^ y) & borrow);
        last_bit    = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            res_reg  <= '0;
            borrow   <= 1'b0;
            count    <= '0;
            diff_reg <= '0;
            bout_reg <= 1'b0;
        end else begin
            if (accept) begin
                a_reg  <= bus.a;
                b_reg  <= bus.b;
                borrow <= bus.bin;
                count  <= '0;
            end else if (state == SHIFT) begin
                a_reg   <= a_reg >> 1;
                b_reg   <= b_reg >> 1;
                res_reg <= {d, res_reg[WIDTH-1:1]};
                borrow  <= borrow_next;
                count   <= count + 1'b1;
                // The final bit lands straight in diff, so the outputs only move on completion.
                if (last_bit) begin
                    diff_reg <= {d, res_reg[WIDTH-1:1]};
                    bout_reg <= borrow_next;
                end
            end
        end
    end

    assign bus.diff = diff_reg;
    assign bus.bout = bout_reg;
    assign bus.busy = busy_int;
    assign bus.done = done_int;
endmodule
